// File: rtl/adler32_check.sv
// Receive-side Adler-32 frame checker: holds back the 4 trailer bytes and compares them with the
// running {B,A}. Optional saturating bad-frame counter when ADLER32_CHK_ERRCNT_EN is defined.
module adler32_check #(
  parameter logic [15:0] MOD = 16'd65521
`ifdef ADLER32_CHK_ERRCNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_runt,
  output logic [31:0]      res_sum
`ifdef ADLER32_CHK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic {ST_ACC, ST_RESULT} state_t;

  state_t      state_q;
  logic [15:0] a_q, b_q;
  logic [2:0]  nb_q;
  logic [7:0]  hb_q [4];

  logic [7:0]  hb_d [4];
  logic [16:0] a_sum, b_sum;
  logic [15:0] a_d, b_d;
  logic [2:0]  nb_d;
  logic        accept, fold, runt_d, ok_d;
  logic [31:0] trailer_d;

  assign in_ready = (state_q == ST_ACC);
  assign accept   = in_valid && (state_q == ST_ACC);
  assign fold     = (nb_q == 3'd4);

  // Holdback line after shifting the incoming byte in; hb[3] is the oldest byte.
  assign hb_d[0] = in_data;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_shift
      assign hb_d[gi] = hb_q[gi-1];
    end
  endgenerate

  always_comb begin
    a_sum = {1'b0, a_q} + {9'd0, hb_q[3]};
    if (a_sum >= {1'b0, MOD}) a_sum = a_sum - {1'b0, MOD};
    b_sum = {1'b0, b_q} + {1'b0, a_sum[15:0]};
    if (b_sum >= {1'b0, MOD}) b_sum = b_sum - {1'b0, MOD};
    a_d       = fold ? a_sum[15:0] : a_q;
    b_d       = fold ? b_sum[15:0] : b_q;
    nb_d      = fold ? nb_q : nb_q + 3'd1;
    runt_d    = (nb_d != 3'd4);
    trailer_d = {hb_d[3], hb_d[2], hb_d[1], hb_d[0]};
    ok_d      = !runt_d && (trailer_d == {b_d, a_d});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACC;
      a_q       <= 16'h0001;
      b_q       <= 16'h0000;
      nb_q      <= 3'd0;
      hb_q      <= '{default: 8'h00};
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      res_runt  <= 1'b0;
      res_sum   <= 32'h0;
`ifdef ADLER32_CHK_ERRCNT_EN
      err_count <= '0;
`endif
    end else if (state_q == ST_ACC) begin
      if (accept) begin
        a_q  <= a_d;
        b_q  <= b_d;
        nb_q <= nb_d;
        hb_q <= hb_d;
        if (in_last) begin
          state_q   <= ST_RESULT;
          res_valid <= 1'b1;
          res_ok    <= ok_d;
          res_runt  <= runt_d;
          res_sum   <= {b_d, a_d};
`ifdef ADLER32_CHK_ERRCNT_EN
          if (!ok_d && (err_count != {CNT_W{1'b1}})) err_count <= err_count + 1'b1;
`endif
        end
      end
    end else begin
      // Verdict cycle: stall input and restart the checksum for the next frame.
      state_q   <= ST_ACC;
      res_valid <= 1'b0;
      a_q       <= 16'h0001;
      b_q       <= 16'h0000;
      nb_q      <= 3'd0;
      hb_q      <= '{default: 8'h00};
    end
  end

endmodule

// File: tb/tb_adler32_check.sv
// Randomised bench for adler32_check against a plain-arithmetic Adler-32 model.
module tb_adler32_check;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        res_valid;
  logic        res_ok;
  logic        res_runt;
  logic [31:0] res_sum;
`ifdef ADLER32_CHK_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulses_exp = 0;
  int bad_frames_exp = 0;

  adler32_check dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .res_valid(res_valid),
    .res_ok   (res_ok),
    .res_runt (res_runt),
    .res_sum  (res_sum)
`ifdef ADLER32_CHK_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_adler(input bq_t d, input int n);
    int unsigned a = 1;
    int unsigned b = 0;
    for (int k = 0; k < n; k++) begin
      a = (a + d[k]) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic bq_t with_trailer(input bq_t p);
    bq_t         f = p;
    logic [31:0] s = ref_adler(p, p.size());
    f.push_back(s[31:24]);
    f.push_back(s[23:16]);
    f.push_back(s[15:8]);
    f.push_back(s[7:0]);
    return f;
  endfunction

  task automatic run_frame(input string name, input bq_t fr, input bit gaps);
    int          n = fr.size();
    int          i = 0;
    int          guard = 0;
    bit          runt, ok, ready_now;
    logic [31:0] sum, trl;
    runt = (n < 4);
    sum  = runt ? 32'h1 : ref_adler(fr, n - 4);
    trl  = runt ? 32'h0 : {fr[n-4], fr[n-3], fr[n-2], fr[n-1]};
    ok   = !runt && (trl == sum);
    while (i < n && guard < 8 * n + 50) begin
      ready_now = in_ready;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = fr[i];
        in_last  = (i == n - 1);
      end
      @(posedge clk); #1;
      guard++;
      if (in_valid && ready_now) i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_xfer"}, i, n);
    check({name, "_vld"}, res_valid, 1);
    check({name, "_rdy0"}, in_ready, 0);
    check({name, "_ok"}, res_ok, ok);
    check({name, "_runt"}, res_runt, runt);
    check({name, "_sum"}, res_sum, sum);
    pulses_exp++;
    if (!ok) bad_frames_exp++;
    $display("frame %-8s len=%0d sum=%08h ok=%0b runt=%0b", name, n, res_sum, res_ok, res_runt);
    @(posedge clk); #1;
    check({name, "_vld0"}, res_valid, 0);
    check({name, "_rdy1"}, in_ready, 1);
`ifdef ADLER32_CHK_ERRCNT_EN
    check({name, "_errcnt"}, err_count, bad_frames_exp);
`endif
  endtask

  initial begin
    bq_t f, p;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", res_valid, 0);
    check("rst_ok", res_ok, 0);
    check("rst_runt", res_runt, 0);
    check("rst_sum", res_sum, 0);
    check("rst_rdy", in_ready, 1);
    rst = 1'b0;

    f = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h62};
    run_frame("t1", f, 0);
    check("t1_lit", res_sum, 32'h00620062);

    p = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    f = p; f.push_back(8'h11); f.push_back(8'hE6); f.push_back(8'h03); f.push_back(8'h98);
    run_frame("wiki", f, 0);
    check("wiki_lit", res_sum, 32'h11E60398);
    f[f.size()-1] = 8'h99;
    run_frame("wikibad", f, 1);
    check("wikibad_ok", res_ok, 0);

    f = '{8'h00, 8'h00, 8'h00, 8'h01};
    run_frame("empty", f, 0);
    f = '{8'hAB, 8'hCD};
    run_frame("runt2", f, 0);
    check("runt2_sum", res_sum, 32'h00000001);

    f = '{8'h61, 8'h62, 8'h63, 8'h02, 8'h4D, 8'h01, 8'h27};
    run_frame("abc", f, 1);
    check("abc_lit", res_sum, 32'h024D0127);

    p.delete();
    repeat (1024) p.push_back(8'hFF);
    run_frame("ff1024", with_trailer(p), 0);
    // A lands exactly on the modulus after this payload and must wrap to zero.
    p.delete();
    repeat (256) p.push_back(8'hFF);
    p.push_back(8'hF0);
    run_frame("awrap", with_trailer(p), 1);

    // Reset in the middle of a frame: partial frame must vanish without a verdict.
    repeat (3) begin
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_vld", res_valid, 0);
    check("mrst_sum", res_sum, 0);
    check("mrst_rdy", in_ready, 1);
    rst = 1'b0;
    bad_frames_exp = 0;
    f = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h62};
    run_frame("t6", f, 0);
    f = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h63};
    run_frame("t6bad", f, 0);
    f = '{8'h5A};
    run_frame("t6runt", f, 1);
`ifdef ADLER32_CHK_ERRCNT_EN
    check("t6_errcnt2", err_count, 2);
`endif

    for (int k = 0; k < 24; k++) begin
      int kind = $urandom_range(0, 7);
      p.delete();
      if (kind == 0) begin
        repeat ($urandom_range(1, 3)) p.push_back(8'($urandom));
        f = p;
      end else begin
        repeat ($urandom_range(0, 40)) p.push_back(8'($urandom));
        f = with_trailer(p);
        if (kind <= 2) begin
          int idx = f.size() - 1 - $urandom_range(0, 3);
          f[idx] = f[idx] ^ 8'($urandom_range(1, 255));
        end
      end
      run_frame($sformatf("rnd%0d", k), f, 1'($urandom));
    end

    check("pulses", pulses, pulses_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
